wb_stage: RTL and testbench

Writeback stage that sits directly upstream of the 32x32 register file and drives its write port (DI, AD, writeen).
- Arbitrates between a single-cycle ALU result channel and a variable-latency load-return channel.
- Registers the winning write for one cycle.
- Keeps a per-register scoreboard of outstanding loads.
- Provides read-port forwarding and busy flags for the decode stage, which reads the register file through A1/A2.

---
 rtl/wb_stage.sv | 127 ++++++++++++
 tb/tb_wb_stage.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU and load results onto the register-file
// write port, tracks outstanding loads, and forwards the pending write.
module wb_stage #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_rd,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_issue,
    input  logic [AW-1:0] ld_issue_rd,
    output logic          ld_issue_ready,
    input  logic [AW-1:0] A1,
    input  logic [AW-1:0] A2,
    output logic [DW-1:0] DI,
    output logic [AW-1:0] AD,
    output logic          writeen,
    output logic          fwd1_hit,
    output logic [DW-1:0] fwd1_data,
    output logic          fwd2_hit,
    output logic [DW-1:0] fwd2_data,
    output logic          busy1,
    output logic          busy2
);

    localparam int NR = 1 << AW;

    // 1: load channel wins the next contended cycle
    logic          prio_ld;
    logic [NR-1:0] busy;
    logic [NR-1:0] busy_nx;
    logic          take;
    logic [DW-1:0] wdata;
    logic [AW-1:0] wrd;
    logic          wr_zero;
    logic          issue_zero;
    logic          set_busy;
    logic          a1_zero;
    logic          a2_zero;

    assign wr_zero    = ZERO_REG && (wrd == '0);
    assign issue_zero = ZERO_REG && (ld_issue_rd == '0);
    assign a1_zero    = ZERO_REG && (A1 == '0);
    assign a2_zero    = ZERO_REG && (A2 == '0);

    // Grant: lone requester wins; on contention the round-robin pointer decides
    always_comb begin
        alu_ready = 1'b0;
        ld_ready  = 1'b0;
        if (!reset) begin
            if (alu_valid && ld_valid) begin
                alu_ready = !prio_ld;
                ld_ready  = prio_ld;
            end else begin
                alu_ready = alu_valid;
                ld_ready  = ld_valid;
            end
        end
    end

    assign take  = alu_ready || ld_ready;
    assign wdata = ld_ready ? ld_data : alu_data;
    assign wrd   = ld_ready ? ld_rd : alu_rd;

    // Pointer flips to the loser only when both sources competed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_ld <= 1'b0;
        end else if (alu_valid && ld_valid) begin
            prio_ld <= alu_ready;
        end
    end

    // Register the granted write; data/address hold when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            DI      <= '0;
            AD      <= '0;
            writeen <= 1'b0;
        end else begin
            writeen <= take && !wr_zero;
            if (take) begin
                DI <= wdata;
                AD <= wrd;
            end
        end
    end

    assign ld_issue_ready = issue_zero || !busy[ld_issue_rd];
    assign set_busy       = ld_issue && ld_issue_ready && !issue_zero;

    // Next scoreboard: returns clear, issues set, and set wins on a tie
    always_comb begin
        busy_nx = busy;
        if (ld_ready) begin
            busy_nx[ld_rd] = 1'b0;
        end
        if (set_busy) begin
            busy_nx[ld_issue_rd] = 1'b1;
        end
    end

    // Outstanding-load scoreboard
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nx;
        end
    end

    assign busy1     = busy[A1];
    assign busy2     = busy[A2];
    assign fwd1_hit  = writeen && (AD == A1) && !a1_zero;
    assign fwd2_hit  = writeen && (AD == A2) && !a2_zero;
    assign fwd1_data = DI;
    assign fwd2_data = DI;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: scoreboarded writeback checks on a ZERO_REG=0
// instance plus a ZERO_REG=1 instance driven by the same stimulus.
module tb_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, ld_valid, ld_issue;
    logic [AW-1:0] alu_rd, ld_rd, ld_issue_rd, A1, A2;
    logic [DW-1:0] alu_data, ld_data;

    logic          alu_ready, ld_ready, ld_issue_ready, writeen;
    logic [DW-1:0] DI, fwd1_data, fwd2_data;
    logic [AW-1:0] AD;
    logic          fwd1_hit, fwd2_hit, busy1, busy2;

    logic          z_alu_ready, z_ld_ready, z_ld_issue_ready, z_writeen;
    logic [DW-1:0] z_DI, z_fwd1_data, z_fwd2_data;
    logic [AW-1:0] z_AD;
    logic          z_fwd1_hit, z_fwd2_hit, z_busy1, z_busy2;

    typedef struct {
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] di;
    } wr_t;

    wr_t           q[$];
    wr_t           w;
    logic [AW-1:0] last_ad;
    logic [DW-1:0] last_di;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    wb_stage #(.DW(DW), .AW(AW), .ZERO_REG(1'b0)) u0 (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .ld_issue_ready(ld_issue_ready),
        .A1(A1), .A2(A2),
        .DI(DI), .AD(AD), .writeen(writeen),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .busy1(busy1), .busy2(busy2)
    );

    wb_stage #(.DW(DW), .AW(AW), .ZERO_REG(1'b1)) u1 (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(z_alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(z_ld_ready),
        .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .ld_issue_ready(z_ld_issue_ready),
        .A1(A1), .A2(A2),
        .DI(z_DI), .AD(z_AD), .writeen(z_writeen),
        .fwd1_hit(z_fwd1_hit), .fwd1_data(z_fwd1_data),
        .fwd2_hit(z_fwd2_hit), .fwd2_data(z_fwd2_data),
        .busy1(z_busy1), .busy2(z_busy2)
    );

    task automatic idle();
        alu_valid   = 1'b0;
        ld_valid    = 1'b0;
        ld_issue    = 1'b0;
        alu_rd      = '0;
        ld_rd       = '0;
        ld_issue_rd = '0;
        alu_data    = '0;
        ld_data     = '0;
    endtask

    task automatic push(input logic we, input logic [AW-1:0] ad,
                        input logic [DW-1:0] di);
        wr_t e;
        if (we) begin
            last_ad = ad;
            last_di = di;
        end
        e.we = we;
        e.ad = last_ad;
        e.di = last_di;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        last_ad = '0;
        last_di = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        alu_valid = 1'b1;
        ld_valid  = 1'b1;
        #1;
        checks++;
        if (writeen !== 1'b0 || AD !== '0 || DI !== '0) begin
            errors++;
            $display("FAIL reset_out: we=%b ad=%0d di=%h want 0/0/0",
                     writeen, AD, DI);
        end
        checks++;
        if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: alu=%b ld=%b want 0/0",
                     alu_ready, ld_ready);
        end
        @(negedge clk);
        reset     = 1'b0;
        alu_rd    = 5'd4;
        alu_data  = 32'hAAAA_0004;
        ld_rd     = 5'd6;
        ld_data   = 32'h6666_6666;
        ld_issue  = 1'b1;
        ld_issue_rd = 5'd7;
        @(negedge clk);
        idle();
        A1 = 5'd7;
        #1;
        checks++;
        if (writeen !== 1'b1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: we=%b busy1=%b want 1/1",
                     writeen, busy1);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (writeen !== 1'b0 || AD !== '0 || DI !== '0 || busy1 !== 1'b0)
        begin
            errors++;
            $display("FAIL reset_async: we=%b ad=%0d di=%h busy1=%b want 0",
                     writeen, AD, DI, busy1);
        end
        @(negedge clk);
        reset     = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        alu_data  = 32'h0000_A001;
        ld_valid  = 1'b1;
        ld_rd     = 5'd2;
        ld_data   = 32'h0000_B002;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_rr: alu=%b ld=%b want 1/0",
                     alu_ready, ld_ready);
        end
        @(negedge clk);
        idle();
        checks++;
        if (writeen !== 1'b1 || AD !== 5'd1 || DI !== 32'h0000_A001) begin
            errors++;
            $display("FAIL reset_first: we=%b ad=%0d di=%h want 1/1/a001",
                     writeen, AD, DI);
        end
    endtask

    task automatic test_single_alu();
        do_reset();
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEAD_BEEF;
        A1        = 5'd5;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL alu_ready: alu=%b ld=%b want 1/0",
                     alu_ready, ld_ready);
        end
        push(1'b1, 5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        idle();
        w = q.pop_front();
        checks++;
        if (writeen !== w.we || AD !== w.ad || DI !== w.di) begin
            errors++;
            $display("FAIL alu_write: we=%b ad=%0d di=%h want %b/%0d/%h",
                     writeen, AD, DI, w.we, w.ad, w.di);
        end
        checks++;
        if (fwd1_hit !== 1'b1 || fwd1_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL alu_fwd1: hit=%b data=%h want 1/deadbeef",
                     fwd1_hit, fwd1_data);
        end
        push(1'b0, '0, '0);
        @(negedge clk);
        w = q.pop_front();
        checks++;
        if (writeen !== w.we || AD !== w.ad || DI !== w.di
            || fwd1_hit !== 1'b0) begin
            errors++;
            $display("FAIL alu_idle: we=%b ad=%0d di=%h hit=%b want %b/%0d/%h/0",
                     writeen, AD, DI, fwd1_hit, w.we, w.ad, w.di);
        end
    endtask

    task automatic test_contention();
        int na;
        int nl;
        logic ga;
        do_reset();
        na = 0;
        nl = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                w = q.pop_front();
                checks++;
                if (writeen !== w.we || AD !== w.ad || DI !== w.di) begin
                    errors++;
                    $display("FAIL cont_wr%0d: we=%b ad=%0d di=%h want %b/%0d/%h",
                             i, writeen, AD, DI, w.we, w.ad, w.di);
                end
            end
            alu_valid = 1'b1;
            alu_rd    = 5'd1;
            alu_data  = 32'hA000_0000 + 32'(na);
            ld_valid  = 1'b1;
            ld_rd     = 5'd2;
            ld_data   = 32'hB000_0000 + 32'(nl);
            ga = (i % 2) == 0;
            #1;
            checks++;
            if (alu_ready !== ga || ld_ready !== !ga) begin
                errors++;
                $display("FAIL cont_grant%0d: alu=%b ld=%b want %b/%b",
                         i, alu_ready, ld_ready, ga, !ga);
            end
            if (ga) begin
                push(1'b1, 5'd1, 32'hA000_0000 + 32'(na));
                na++;
            end else begin
                push(1'b1, 5'd2, 32'hB000_0000 + 32'(nl));
                nl++;
            end
        end
        @(negedge clk);
        idle();
        w = q.pop_front();
        checks++;
        if (writeen !== w.we || AD !== w.ad || DI !== w.di) begin
            errors++;
            $display("FAIL cont_wr4: we=%b ad=%0d di=%h want %b/%0d/%h",
                     writeen, AD, DI, w.we, w.ad, w.di);
        end
    endtask

    task automatic test_scoreboard();
        do_reset();
        A2          = 5'd9;
        ld_issue    = 1'b1;
        ld_issue_rd = 5'd9;
        #1;
        checks++;
        if (ld_issue_ready !== 1'b1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL sb_issue: rdy=%b busy2=%b want 1/0",
                     ld_issue_ready, busy2);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy2 !== 1'b1 || ld_issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL sb_busy: busy2=%b rdy=%b want 1/0",
                     busy2, ld_issue_ready);
        end
        @(negedge clk);
        ld_issue = 1'b0;
        ld_valid = 1'b1;
        ld_rd    = 5'd9;
        ld_data  = 32'h0000_1234;
        #1;
        checks++;
        if (ld_ready !== 1'b1 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL sb_ret: ld_ready=%b busy2=%b want 1/1",
                     ld_ready, busy2);
        end
        push(1'b1, 5'd9, 32'h0000_1234);
        @(negedge clk);
        idle();
        w = q.pop_front();
        checks++;
        if (writeen !== w.we || AD !== w.ad || DI !== w.di) begin
            errors++;
            $display("FAIL sb_write: we=%b ad=%0d di=%h want %b/%0d/%h",
                     writeen, AD, DI, w.we, w.ad, w.di);
        end
        checks++;
        if (busy2 !== 1'b0 || fwd2_hit !== 1'b1
            || fwd2_data !== 32'h0000_1234) begin
            errors++;
            $display("FAIL sb_clear: busy2=%b hit=%b data=%h want 0/1/1234",
                     busy2, fwd2_hit, fwd2_data);
        end
    endtask

    task automatic test_set_clear();
        do_reset();
        A1          = 5'd3;
        ld_valid    = 1'b1;
        ld_rd       = 5'd3;
        ld_data     = 32'h3333_3333;
        ld_issue    = 1'b1;
        ld_issue_rd = 5'd3;
        #1;
        checks++;
        if (ld_ready !== 1'b1 || ld_issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL sc_ready: ld=%b issue=%b want 1/1",
                     ld_ready, ld_issue_ready);
        end
        push(1'b1, 5'd3, 32'h3333_3333);
        @(negedge clk);
        idle();
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h0BAD_0003;
        w = q.pop_front();
        checks++;
        if (writeen !== w.we || AD !== w.ad || DI !== w.di
            || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL sc_write: we=%b ad=%0d di=%h busy1=%b want %b/%0d/%h/1",
                     writeen, AD, DI, busy1, w.we, w.ad, w.di);
        end
        push(1'b1, 5'd3, 32'h0BAD_0003);
        @(negedge clk);
        idle();
        w = q.pop_front();
        checks++;
        if (writeen !== w.we || AD !== w.ad || DI !== w.di
            || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL sc_alu: we=%b ad=%0d di=%h busy1=%b want %b/%0d/%h/1",
                     writeen, AD, DI, busy1, w.we, w.ad, w.di);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        A1        = 5'd0;
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'h5555_5555;
        #1;
        checks++;
        if (z_alu_ready !== 1'b1 || alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL z_ready: z=%b n=%b want 1/1",
                     z_alu_ready, alu_ready);
        end
        push(1'b1, 5'd0, 32'h5555_5555);
        @(negedge clk);
        idle();
        w = q.pop_front();
        checks++;
        if (writeen !== w.we || AD !== w.ad || DI !== w.di
            || fwd1_hit !== 1'b1) begin
            errors++;
            $display("FAIL z_nz_write: we=%b ad=%0d di=%h hit=%b want %b/%0d/%h/1",
                     writeen, AD, DI, fwd1_hit, w.we, w.ad, w.di);
        end
        checks++;
        if (z_writeen !== 1'b0 || z_fwd1_hit !== 1'b0) begin
            errors++;
            $display("FAIL z_write: we=%b hit=%b want 0/0",
                     z_writeen, z_fwd1_hit);
        end
        ld_issue    = 1'b1;
        ld_issue_rd = 5'd0;
        #1;
        checks++;
        if (z_ld_issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL z_issue: rdy=%b want 1", z_ld_issue_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (z_busy1 !== 1'b0 || z_ld_issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL z_busy: busy1=%b rdy=%b want 0/1",
                     z_busy1, z_ld_issue_ready);
        end
        checks++;
        if (busy1 !== 1'b1 || ld_issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL z_nz_busy: busy1=%b rdy=%b want 1/0",
                     busy1, ld_issue_ready);
        end
        idle();
    endtask

    initial begin
        A1 = '0;
        A2 = '0;
        last_ad = '0;
        last_di = '0;
        test_reset();
        test_single_alu();
        test_contention();
        test_scoreboard();
        test_set_clear();
        test_zero_reg();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
